calc_result_collector: RTL and testbench

Read-side partner of the calcengine perceptron array. The array's mode is skewed one cycle per lane, so lane i's result on out_bus is valid i cycles after lane 0.
This block samples each lane at its skewed cycle and reassembles complete result rows in a small row buffer. It then streams the rows out one lane-result per beat over a valid/ready handshake, toward write-back/activation logic.

---
 rtl/calc_result_collector_pkg.sv | 24 ++
 rtl/res_tokenshr.sv | 46 ++++
 rtl/calc_result_collector.sv | 134 +++++++++++++
 tb/tb_calc_result_collector.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_result_collector_pkg.sv
// Shared constants and token type for the calcengine result path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc_result_collector_pkg;

    localparam int N     = 40;               // lanes (perceptrons)
    localparam int Ba    = 24;               // result width per lane
    localparam int DEPTH = 4;                // rows in the row buffer, power of 2
    localparam int LW    = $clog2(N);        // lane index width
    localparam int SW    = $clog2(DEPTH);    // row slot index width
    localparam int CW    = $clog2(DEPTH + 1); // row counter width (0..DEPTH)

    // Capture token: travels down the skew chain with its row's slot.
    typedef struct packed {
        logic          vld;
        logic [SW-1:0] slot;
    } token_t;

    // Slot pointer advance; wraps for free because DEPTH is a power of 2.
    function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/res_tokenshr.sv
// Token skew chain: stage i holds the token that captures lane i at this edge.
// Latency: stage 0 is the injected token itself, stage i lags it by i cycles.
// Backpressure: none; shifts every cycle, mirroring the engine's mode skew.
// Ports: clk, rst (async active-low), tok_in (token injected this cycle),
//        stage[0..N-1] (token seen by each lane at the coming edge).
module res_tokenshr
    import calc_result_collector_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  token_t tok_in,
    output token_t stage [N]
);

    token_t pipe_q [1:N-1];
    token_t pipe_d [1:N-1];

    always_comb begin
        pipe_d[1] = tok_in;
        for (int i = 2; i < N; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < N; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < N; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Lane 0 is written on the very edge the start is seen, so stage 0 is
    // the unregistered injection point.
    always_comb begin
        stage[0] = tok_in;
        for (int i = 1; i < N; i++) begin
            stage[i] = pipe_q[i];
        end
    end

endmodule

// File: rtl/calc_result_collector.sv
// Reassembles skewed per-lane engine results into rows and streams them one lane per beat.
// Latency: first beat of a row is valid N cycles after its start.
// Backpressure: res_ready low holds all res_* stable; starts beyond DEPTH pending rows are dropped and flagged.
// Ports: clk, rst (async active-low); out_bus/start/mode from the engine; clr_ovf;
//        res_data/res_lane/res_mode/res_last/res_valid with res_ready; busy, overflow status.
module calc_result_collector
    import calc_result_collector_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [N*Ba-1:0] out_bus,
    input  logic            start,
    input  logic            mode,
    input  logic            clr_ovf,
    output logic [Ba-1:0]   res_data,
    output logic [LW-1:0]   res_lane,
    output logic            res_mode,
    output logic            res_last,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            busy,
    output logic            overflow
);

    logic [SW-1:0] wr_ptr_q, wr_ptr_d;
    logic [SW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0] ready_rows_q, ready_rows_d;
    logic [LW-1:0] lane_cnt_q, lane_cnt_d;
    logic          ovf_q, ovf_d;

    // Row storage and tags are not reset: nothing reads them until a row
    // has been fully captured since the last reset.
    logic [Ba-1:0] row_buf_q [DEPTH][N];
    logic          tag_q     [DEPTH];

    token_t tok_in;
    token_t stage [N];

    logic vld_c, beat, last_beat, accept, reject, complete, tok_any;

    res_tokenshr u_tokenshr (
        .clk    (clk),
        .rst    (rst),
        .tok_in (tok_in),
        .stage  (stage)
    );

    always_comb begin
        vld_c     = (ready_rows_q != '0);
        beat      = vld_c & res_ready;
        last_beat = beat & (lane_cnt_q == LW'(N-1));
        // A slot freed by this edge's last beat may be reused immediately:
        // the new row's lane 0 lands where the old row's lane 0 was already read.
        accept    = start & ((alloc_cnt_q < CW'(DEPTH)) | last_beat);
        reject    = start & ~accept;
        complete  = stage[N-1].vld;

        tok_in.vld  = accept;
        tok_in.slot = wr_ptr_q;

        wr_ptr_d   = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lane_cnt_d = lane_cnt_q;
        if (last_beat) begin
            lane_cnt_d = '0;
            rd_ptr_d   = ptr_inc(rd_ptr_q);
        end else if (beat) begin
            lane_cnt_d = lane_cnt_q + 1'b1;
        end

        // Increment and decrement in the same cycle net to no change.
        alloc_cnt_d  = alloc_cnt_q + CW'(accept) - CW'(last_beat);
        ready_rows_d = ready_rows_q + CW'(complete) - CW'(last_beat);

        // A drop in the same cycle as a clear must stay visible.
        if (reject) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        tok_any = 1'b0;
        for (int i = 1; i < N; i++) begin
            tok_any = tok_any | stage[i].vld;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            alloc_cnt_q  <= '0;
            ready_rows_q <= '0;
            lane_cnt_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            alloc_cnt_q  <= alloc_cnt_d;
            ready_rows_q <= ready_rows_d;
            lane_cnt_q   <= lane_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    // Each live token writes only its own lane of its own slot, so
    // overlapping captures never touch the same entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (stage[i].vld) begin
                row_buf_q[stage[i].slot][i] <= out_bus[i*Ba +: Ba];
            end
        end
        if (accept) begin
            tag_q[wr_ptr_q] <= mode;
        end
    end

    // Outputs are forced to zero when no row is pending so stale buffer
    // contents never show on the interface.
    always_comb begin
        res_valid = vld_c;
        res_data  = vld_c ? row_buf_q[rd_ptr_q][lane_cnt_q] : '0;
        res_lane  = lane_cnt_q;
        res_mode  = vld_c & tag_q[rd_ptr_q];
        res_last  = vld_c & (lane_cnt_q == LW'(N-1));
        busy      = tok_any | (alloc_cnt_q != '0);
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_calc_result_collector.sv
module tb_calc_result_collector;
    import calc_result_collector_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*Ba-1:0] out_bus;
    logic            start, mode, clr_ovf, res_ready;
    logic [Ba-1:0]   res_data;
    logic [LW-1:0]   res_lane;
    logic            res_mode, res_last, res_valid, busy, overflow;

    always #5 clk = ~clk;

    calc_result_collector dut (
        .clk       (clk),
        .rst       (rst),
        .out_bus   (out_bus),
        .start     (start),
        .mode      (mode),
        .clr_ovf   (clr_ovf),
        .res_data  (res_data),
        .res_lane  (res_lane),
        .res_mode  (res_mode),
        .res_last  (res_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [Ba-1:0] data;
        logic [LW-1:0] lane;
        logic          mode;
        logic          last;
    } beat_t;

    beat_t exp_q [$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    endtask

    task automatic push_beat(input int data, input int lane, input logic m);
        beat_t b;
        b.data = Ba'(data);
        b.lane = LW'(lane);
        b.mode = m;
        b.last = (lane == N-1);
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes_const(input int base);
        for (int i = 0; i < N; i++) out_bus[i*Ba +: Ba] = Ba'(base + i);
    endtask

    task automatic set_lanes_cyc(input int off, input int c);
        for (int i = 0; i < N; i++) out_bus[i*Ba +: Ba] = Ba'(off + 1000*c + i);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    // Monitor: pops the scoreboard on every accepted beat, and checks that a
    // stalled beat is presented unchanged on the following cycle.
    beat_t held;
    logic  stalled = 1'b0;
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 32'(res_valid), 32'd1);
                    check("stall_data",  32'(res_data),  32'(held.data));
                    check("stall_lane",  32'(res_lane),  32'(held.lane));
                    check("stall_mode",  32'(res_mode),  32'(held.mode));
                    check("stall_last",  32'(res_last),  32'(held.last));
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_beat: actual lane=%0d data=%0d required=no beat",
                                 res_lane, res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(res_data), 32'(e.data));
                        check("beat_lane", 32'(res_lane), 32'(e.lane));
                        check("beat_mode", 32'(res_mode), 32'(e.mode));
                        check("beat_last", 32'(res_last), 32'(e.last));
                    end
                end
                stalled   = res_valid && !res_ready;
                held.data = res_data;
                held.lane = res_lane;
                held.mode = res_mode;
                held.last = res_last;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; mode = 1'b0; clr_ovf = 1'b0; res_ready = 1'b0;
        out_bus = '0;
        repeat (3) tick();
        check("rst_valid",    32'(res_valid), 32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_data",     32'(res_data),  32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_valid", 32'(res_valid), 32'd0);
        check("post_rst_lane",  32'(res_lane),  32'd0);

        // 1: single row, ready held high, latency check
        res_ready = 1'b1;
        set_lanes_const(1);
        for (int i = 0; i < N; i++) push_beat(i + 1, i, 1'b1);
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        repeat (38) tick();
        check("t1_valid_early", 32'(res_valid), 32'd0);
        tick();
        check("t1_valid_first", 32'(res_valid), 32'd1);
        check("t1_first_data",  32'(res_data),  32'd1);
        drain(100);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: three back-to-back starts, lane value depends on capture cycle
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) push_beat(1000*(r+i) + i, i, (r == 1));
        for (int c = 0; c < 42; c++) begin
            set_lanes_cyc(0, c);
            start = (c < 3);
            mode  = (c == 1);
            tick();
        end
        start = 1'b0; mode = 1'b0;
        drain(200);

        // 3: one row under toggling backpressure
        res_ready = 1'b0;
        set_lanes_const(500);
        for (int i = 0; i < N; i++) push_beat(500 + i, i, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
            res_ready = ~res_ready;
            tick();
        end
        check("t3_empty", 32'(exp_q.size()), 32'd0);
        res_ready = 1'b1;
        repeat (3) tick();

        // 4: overflow with consumer stalled
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_lanes_const(10000*(k+1));
            for (int i = 0; i < N; i++) push_beat(10000*(k+1) + i, i, (k % 2 == 1));
            start = 1'b1; mode = (k % 2 == 1);
            tick();
            start = 1'b0; mode = 1'b0;
            repeat (49) tick();
        end
        check("t4_ovf_before", 32'(overflow), 32'd0);
        set_lanes_const(50000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_ovf_set", 32'(overflow), 32'd1);
        repeat (45) tick();
        res_ready = 1'b1;
        drain(300);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'd0);

        // 5: reset in the middle of a capture
        set_lanes_const(777);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b0;
        #1;
        check("t5_valid", 32'(res_valid), 32'd0);
        check("t5_data",  32'(res_data),  32'd0);
        check("t5_lane",  32'(res_lane),  32'd0);
        check("t5_mode",  32'(res_mode),  32'd0);
        check("t5_last",  32'(res_last),  32'd0);
        check("t5_busy",  32'(busy),      32'd0);
        check("t5_ovf",   32'(overflow),  32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (60) tick();
        check("t5_no_row", 32'(res_valid), 32'd0);
        check("t5_idle",   32'(busy),      32'd0);
        set_lanes_const(900);
        for (int i = 0; i < N; i++) push_beat(900 + i, i, 1'b1);
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        drain(100);

        // 6: buffer full, new start on the edge of row 0's last beat
        res_ready = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < N; i++) push_beat(300000 + 1000*(r+i) + i, i, (r % 2 == 1));
        for (int c = 0; c < 46; c++) begin
            set_lanes_cyc(300000, c);
            start = (c < 4);
            mode  = (c % 2 == 1);
            tick();
        end
        start = 1'b0; mode = 1'b0;
        set_lanes_const(7000);
        res_ready = 1'b1;
        for (int j = 0; j < N; j++) begin
            start = (j == N-1);
            mode  = 1'b1;
            tick();
        end
        start = 1'b0; mode = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < N; i++) push_beat(7000 + i, i, 1'b1);
        check("t6_ovf_clear", 32'(overflow), 32'd0);
        check("t6_busy",      32'(busy),     32'd1);
        repeat (45) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_full_again", 32'(overflow), 32'd1);
        res_ready = 1'b1;
        drain(300);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t6_ovf_clr", 32'(overflow), 32'd0);
        check("t6_idle",    32'(busy),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
